// File: rtl/clk_divider_multi.sv
// Multi-channel clock divider. Each channel counts enabled system-clock cycles
// against its own runtime-programmable divisor and produces a one-cycle tick
// plus a 50% duty square wave. New divisors are staged in a shadow register and
// applied only on a period boundary, on sync, or at once on an idle channel.
module clk_divider_multi #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DEFAULT_DIV = 100000000,
   parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              div_wr,
   input  logic [CH_W-1:0]   div_ch,
   input  logic [CNT_W-1:0]  div_val,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] out_clk,
   output logic [NUM_CH-1:0] pending
);

   localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0]  count_q   [NUM_CH];
   logic [CNT_W-1:0]  div_act_q [NUM_CH];
   logic [CNT_W-1:0]  div_shd_q [NUM_CH];
   logic [NUM_CH-1:0] tick_q;
   logic [NUM_CH-1:0] out_clk_q;
   logic [NUM_CH-1:0] pending_q;

   logic [NUM_CH-1:0] wr_hit;
   logic [NUM_CH-1:0] idle;
   logic [NUM_CH-1:0] terminal;

   // Per-channel decode: write target, halted/disabled, and last count of period.
   // A div_ch value at or beyond NUM_CH matches no channel, so the write is dropped.
   always_comb begin
      wr_hit   = '0;
      idle     = '0;
      terminal = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_hit[i]   = div_wr && (div_ch == CH_W'(i));
         idle[i]     = !en[i] || (div_act_q[i] == '0);
         terminal[i] = (count_q[i] == (div_act_q[i] - CNT_W'(1)));
      end
   end

   // Channel state update: sync > idle > terminal > count, per channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            count_q[i]   <= '0;
            div_act_q[i] <= DefDiv;
            div_shd_q[i] <= DefDiv;
         end
         tick_q    <= '0;
         out_clk_q <= '0;
         pending_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            // Shadow always tracks the latest write so repeated writes keep only the last.
            if (wr_hit[i]) begin
               div_shd_q[i] <= div_val;
            end

            if (sync) begin
               count_q[i]   <= '0;
               out_clk_q[i] <= 1'b0;
               tick_q[i]    <= 1'b0;
               pending_q[i] <= 1'b0;
               // A write landing on the apply edge bypasses the shadow.
               if (wr_hit[i]) begin
                  div_act_q[i] <= div_val;
               end else if (pending_q[i]) begin
                  div_act_q[i] <= div_shd_q[i];
               end
            end else if (idle[i]) begin
               tick_q[i] <= 1'b0;
               if (pending_q[i]) begin
                  // Idle channel takes the staged divisor at once and restarts its period.
                  div_act_q[i] <= wr_hit[i] ? div_val : div_shd_q[i];
                  pending_q[i] <= 1'b0;
                  count_q[i]   <= '0;
               end else if (wr_hit[i]) begin
                  pending_q[i] <= 1'b1;
               end
            end else if (terminal[i]) begin
               count_q[i]   <= '0;
               tick_q[i]    <= 1'b1;
               out_clk_q[i] <= ~out_clk_q[i];
               pending_q[i] <= 1'b0;
               if (wr_hit[i]) begin
                  div_act_q[i] <= div_val;
               end else if (pending_q[i]) begin
                  div_act_q[i] <= div_shd_q[i];
               end
            end else begin
               count_q[i] <= count_q[i] + CNT_W'(1);
               tick_q[i]  <= 1'b0;
               if (wr_hit[i]) begin
                  pending_q[i] <= 1'b1;
               end
            end
         end
      end
   end

   assign tick    = tick_q;
   assign out_clk = out_clk_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: a 4-channel instance with divisor 5 at
// reset, plus a 3-channel instance used to exercise an out-of-range channel select.
module tb_clk_divider_multi;

   logic        clk;
   logic        rst_n;
   logic [3:0]  en;
   logic        sync;
   logic        div_wr;
   logic [1:0]  div_ch;
   logic [31:0] div_val;
   logic [3:0]  tick;
   logic [3:0]  out_clk;
   logic [3:0]  pending;

   logic [2:0]  en3;
   logic        sync3;
   logic        div_wr3;
   logic [1:0]  div_ch3;
   logic [31:0] div_val3;
   logic [2:0]  tick3;
   logic [2:0]  out_clk3;
   logic [2:0]  pending3;

   int n_cmp = 0;
   int n_err = 0;

   logic t0, t1, t2;
   logic oc0, oc1, oc2;
   logic [2:0] oc3;

   clk_divider_multi #(
      .CNT_W      (32),
      .NUM_CH     (4),
      .DEFAULT_DIV(5)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .sync   (sync),
      .div_wr (div_wr),
      .div_ch (div_ch),
      .div_val(div_val),
      .tick   (tick),
      .out_clk(out_clk),
      .pending(pending)
   );

   clk_divider_multi #(
      .CNT_W      (32),
      .NUM_CH     (3),
      .DEFAULT_DIV(2)
   ) u_dut3 (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en3),
      .sync   (sync3),
      .div_wr (div_wr3),
      .div_ch (div_ch3),
      .div_val(div_val3),
      .tick   (tick3),
      .out_clk(out_clk3),
      .pending(pending3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 4'b0000;
      sync     = 1'b0;
      div_wr   = 1'b0;
      div_ch   = 2'd0;
      div_val  = 32'd0;
      en3      = 3'b000;
      sync3    = 1'b0;
      div_wr3  = 1'b0;
      div_ch3  = 2'd0;
      div_val3 = 32'd0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_tick", tick, 4'b0000);
      chk("rst_oclk", out_clk, 4'b0000);
      chk("rst_pend", pending, 4'b0000);
      chk("rst_tick3", {1'b0, tick3}, 4'b0000);

      // Release reset and run ch0 alone at the default divisor of 5
      rst_n = 1'b1;
      en    = 4'b0001;
      oc0 = 1'b0; oc1 = 1'b0; oc2 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         t0 = (k % 5 == 4);
         if (t0) oc0 = ~oc0;
         chk("d5_tick", tick, {3'b000, t0});
         chk("d5_oclk", out_clk, {3'b000, oc0});
      end

      // Write 3 while ch0 sits at count 1: old period completes, then period 3
      for (int k = 20; k < 36; k++) begin
         @(negedge clk);
         t0 = (k == 24) || (k > 24 && ((k - 24) % 3 == 0));
         if (t0) oc0 = ~oc0;
         chk("d3_tick", tick, {3'b000, t0});
         chk("d3_oclk", out_clk, {3'b000, oc0});
         chk("d3_pend", pending, {3'b000, (k >= 21 && k <= 23)});
         div_wr  = (k == 20);
         div_ch  = 2'd0;
         div_val = 32'd3;
      end

      // Write 4 to ch0 exactly on its terminal edge, stage 6 on idle ch1, then sync
      div_wr  = 1'b1;
      div_ch  = 2'd0;
      div_val = 32'd4;
      for (int k = 36; k < 55; k++) begin
         @(negedge clk);
         t0 = (k == 36) || (k == 40) || (k == 45) || (k == 49) || (k == 53);
         t1 = (k == 47) || (k == 53);
         if (k == 41) begin
            oc0 = 1'b0;
            oc1 = 1'b0;
         end
         if (t0) oc0 = ~oc0;
         if (t1) oc1 = ~oc1;
         chk("sy_tick", tick, {2'b00, t1, t0});
         chk("sy_oclk", out_clk, {2'b00, oc1, oc0});
         chk("sy_pend", pending, {2'b00, (k == 37), 1'b0});
         div_wr  = (k == 36);
         div_ch  = 2'd1;
         div_val = 32'd6;
         en      = (k >= 38) ? 4'b0011 : 4'b0001;
         sync    = (k == 40);
      end

      // Drop en0 at count 2 for 7 cycles; ch1 keeps running
      for (int k = 55; k < 67; k++) begin
         @(negedge clk);
         t0 = (k == 64);
         t1 = (k == 59) || (k == 65);
         if (t0) oc0 = ~oc0;
         if (t1) oc1 = ~oc1;
         chk("en_tick", tick, {2'b00, t1, t0});
         chk("en_oclk", out_clk, {2'b00, oc1, oc0});
         en = (k >= 55 && k < 62) ? 4'b0010 : 4'b0011;
      end

      // ch2 alone: write 0 mid-period (halts after that period), later write 2
      en = 4'b0100;
      for (int k = 67; k < 84; k++) begin
         @(negedge clk);
         t2 = (k == 71) || (k == 78) || (k == 80) || (k == 82);
         if (t2) oc2 = ~oc2;
         chk("h_tick", tick, {1'b0, t2, 2'b00});
         chk("h_oclk", out_clk, {1'b0, oc2, oc1, oc0});
         chk("h_pend", pending, {1'b0, (k == 69 || k == 70 || k == 75), 2'b00});
         div_wr  = (k == 68) || (k == 74);
         div_ch  = 2'd2;
         div_val = (k == 68) ? 32'd0 : 32'd2;
      end

      // Out-of-range channel write on the 3-channel instance must be dropped
      en3      = 3'b111;
      div_wr3  = 1'b1;
      div_ch3  = 2'd3;
      div_val3 = 32'd7;
      oc3      = 3'b000;
      for (int k = 84; k < 90; k++) begin
         @(negedge clk);
         t2 = (k % 2 == 0);
         if (t2) oc2 = ~oc2;
         if (k % 2 == 1) oc3 = ~oc3;
         chk("oor_pend3", {1'b0, pending3}, 4'b0000);
         chk("oor_tick3", {1'b0, tick3}, (k % 2 == 1) ? 4'b0111 : 4'b0000);
         chk("oor_oclk3", {1'b0, out_clk3}, {1'b0, oc3});
         chk("oor_tick", tick, {1'b0, t2, 2'b00});
         chk("oor_oclk", out_clk, {1'b0, oc2, oc1, oc0});
         chk("oor_pend", pending, (k == 89) ? 4'b1000 : 4'b0000);
         div_wr3 = 1'b0;
         div_wr  = (k == 88);
         div_ch  = 2'd3;
         div_val = 32'd9;
      end
      div_wr = 1'b0;

      // Asynchronous reset between clock edges clears outputs at once
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_tick", tick, 4'b0000);
      chk("ar_oclk", out_clk, 4'b0000);
      chk("ar_pend", pending, 4'b0000);
      chk("ar_oclk3", {1'b0, out_clk3}, 4'b0000);
      chk("ar_tick3", {1'b0, tick3}, 4'b0000);

      // After reset ch0 is back on the default divisor of 5
      @(negedge clk);
      rst_n = 1'b1;
      en    = 4'b0001;
      en3   = 3'b000;
      oc0   = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         t0 = (k % 5 == 4);
         if (t0) oc0 = ~oc0;
         chk("pr_tick", tick, {3'b000, t0});
         chk("pr_oclk", out_clk, {3'b000, oc0});
      end
      chk("pr_pend", pending, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
